// File: rtl/fifo_pkg.sv
// Shared types and elaboration helpers for the parametrised FIFO family.
// Imported by param_fifo and by the CSR block that aggregates FIFO status.
package fifo_pkg;

    // Returns 1 only for positive powers of two.
    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    // Pointer width carries one extra wrap bit above the storage index.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage: one registered write port and one asynchronous read port.
// Deliberately unreset so synthesis can map it onto distributed RAM.
module fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// Single-clock show-ahead FIFO with occupancy count, programmable almost flags,
// synchronous flush and sticky overflow/underflow error flags.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 64,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     req,
    input  logic [WIDTH-1:0]         req_data,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     rsp,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     err_clr,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);
    localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

    if (!is_pow2(DEPTH) || (DEPTH < 2)) begin : g_bad_depth
        $error("param_fifo: DEPTH must be a power of two and at least 2");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
        $error("param_fifo: AF_THRESH must lie in 1..DEPTH");
    end
    if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
        $error("param_fifo: AE_THRESH must lie in 0..DEPTH-1");
    end

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    fifo_err_t     err_q;
    fifo_err_t     err_d;
    logic          pop_ok;
    logic          push_ok;

    assign empty        = (rd_ptr == wr_ptr);
    assign full         = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
    assign level        = wr_ptr - rd_ptr;
    assign almost_full  = (level >= AF_LVL);
    assign almost_empty = (level <= AE_LVL);

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign pop_ok  = rsp && !empty;
    assign push_ok = req && (!full || pop_ok);

    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = '0;
        end
        if (req && !push_ok && !flush) begin
            err_d.overflow = 1'b1;
        end
        if (rsp && empty && !flush) begin
            err_d.underflow = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            err_q  <= '0;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (pop_ok) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                if (push_ok) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
            end
            err_q <= err_d;
        end
    end

    assign overflow  = err_q.overflow;
    assign underflow = err_q.underflow;

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok && !flush),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (req_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rsp_data)
    );

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo: directed scenarios plus a randomized
// run, all compared against a queue-based reference model.
module tb_param_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 64;
    localparam int AFT   = 60;
    localparam int AET   = 4;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             req;
    logic [WIDTH-1:0] req_data;
    logic             full;
    logic             almost_full;
    logic             rsp;
    logic [WIDTH-1:0] rsp_data;
    logic             empty;
    logic             almost_empty;
    logic [6:0]       level;
    logic             err_clr;
    logic             overflow;
    logic             underflow;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] mq[$];
    bit               m_ovf;
    bit               m_unf;

    param_fifo #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (AFT),
        .AE_THRESH (AET)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .req          (req),
        .req_data     (req_data),
        .full         (full),
        .almost_full  (almost_full),
        .rsp          (rsp),
        .rsp_data     (rsp_data),
        .empty        (empty),
        .almost_empty (almost_empty),
        .level        (level),
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock, applying the current inputs to the reference model.
    task automatic cycle();
        int n = mq.size();
        bit pop_m  = 1'b0;
        bit push_m = 1'b0;
        bit ovf_e  = 1'b0;
        bit unf_e  = 1'b0;
        if (flush) begin
            mq.delete();
        end else begin
            pop_m  = rsp && (n > 0);
            push_m = req && ((n < DEPTH) || pop_m);
            ovf_e  = req && !push_m;
            unf_e  = rsp && (n == 0);
            if (pop_m)  void'(mq.pop_front());
            if (push_m) mq.push_back(req_data);
        end
        m_ovf = ovf_e || (m_ovf && !err_clr);
        m_unf = unf_e || (m_unf && !err_clr);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; req = 0; rsp = 0; err_clr = 0; req_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (level !== 7'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (almost_empty !== 1'b1) begin failures++; $display("FAIL reset_ae got=%b exp=1", almost_empty); end
        checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_af got=%b exp=0", almost_full); end
        checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL reset_err got=%b%b exp=00", overflow, underflow); end
        reset = 1'b0;
        mq.delete(); m_ovf = 0; m_unf = 0;
        cycle();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL post_reset_empty got=%b exp=1", empty); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            req = 1; req_data = WIDTH'(i);
            cycle();
            checks++; if (level !== 7'(mq.size())) begin failures++; $display("FAIL fill_level i=%0d got=%0d exp=%0d", i, level, mq.size()); end
            checks++; if (full !== (i == DEPTH - 1)) begin failures++; $display("FAIL fill_full i=%0d got=%b", i, full); end
            checks++; if (almost_full !== (mq.size() >= AFT)) begin failures++; $display("FAIL fill_af i=%0d got=%b", i, almost_full); end
            checks++; if (rsp_data !== 32'd0) begin failures++; $display("FAIL fill_head i=%0d got=%0d exp=0", i, rsp_data); end
            checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fill_ovf i=%0d got=%b exp=0", i, overflow); end
        end
        idle_inputs();
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 10; i++) begin
            checks++; if (rsp_data !== WIDTH'(i)) begin failures++; $display("FAIL fpp_pop i=%0d got=%0d exp=%0d", i, rsp_data, i); end
            req = 1; rsp = 1; req_data = WIDTH'(100 + i);
            cycle();
            checks++; if (full !== 1'b1) begin failures++; $display("FAIL fpp_full i=%0d got=%b exp=1", i, full); end
            checks++; if (level !== 7'd64) begin failures++; $display("FAIL fpp_level i=%0d got=%0d exp=64", i, level); end
            checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fpp_ovf i=%0d got=%b exp=0", i, overflow); end
        end
        idle_inputs();
    endtask

    task automatic test_overflow_and_drain();
        req = 1; req_data = 32'hFF;
        cycle();
        idle_inputs();
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        checks++; if (level !== 7'd64) begin failures++; $display("FAIL ovf_level got=%0d exp=64", level); end
        cycle();
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (rsp_data !== mq[0]) begin failures++; $display("FAIL drain_data i=%0d got=%0d exp=%0d", i, rsp_data, mq[0]); end
            rsp = 1;
            cycle();
            checks++; if (almost_empty !== (mq.size() <= AET)) begin failures++; $display("FAIL drain_ae i=%0d got=%b", i, almost_empty); end
        end
        idle_inputs();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", empty); end
        err_clr = 1;
        cycle();
        err_clr = 0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
    endtask

    task automatic test_empty_push_pop();
        req = 1; rsp = 1; req_data = 32'hA5;
        cycle();
        idle_inputs();
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL epp_unf got=%b exp=1", underflow); end
        checks++; if (level !== 7'd1) begin failures++; $display("FAIL epp_level got=%0d exp=1", level); end
        checks++; if (rsp_data !== 32'hA5) begin failures++; $display("FAIL epp_data got=%h exp=a5", rsp_data); end
        err_clr = 1;
        cycle();
        err_clr = 0;
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL unf_clr got=%b exp=0", underflow); end
        rsp = 1;
        cycle();
        // Clear coinciding with a fresh underflow: set must win.
        rsp = 1; err_clr = 1;
        cycle();
        idle_inputs();
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL set_wins got=%b exp=1", underflow); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL set_wins_empty got=%b exp=1", empty); end
        err_clr = 1;
        cycle();
        err_clr = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            req = 1'($urandom_range(0, 1));
            rsp = 1'($urandom_range(0, 1));
            req_data = $urandom;
            cycle();
            checks++; if (level !== 7'(mq.size())) begin failures++; $display("FAIL rnd_level i=%0d got=%0d exp=%0d", i, level, mq.size()); end
            checks++; if (empty !== (mq.size() == 0)) begin failures++; $display("FAIL rnd_empty i=%0d got=%b", i, empty); end
            checks++; if (almost_empty !== (mq.size() <= AET)) begin failures++; $display("FAIL rnd_ae i=%0d got=%b", i, almost_empty); end
            checks++; if (full !== (mq.size() == DEPTH)) begin failures++; $display("FAIL rnd_full i=%0d got=%b", i, full); end
            checks++; if ({overflow, underflow} !== {m_ovf, m_unf}) begin failures++; $display("FAIL rnd_err i=%0d got=%b%b exp=%b%b", i, overflow, underflow, m_ovf, m_unf); end
            if (mq.size() > 0) begin
                checks++; if (rsp_data !== mq[0]) begin failures++; $display("FAIL rnd_data i=%0d got=%h exp=%h", i, rsp_data, mq[0]); end
            end
        end
        idle_inputs();
        err_clr = 1;
        cycle();
        err_clr = 0;
    endtask

    task automatic test_flush();
        while (mq.size() < 30) begin
            req = 1; req_data = $urandom;
            cycle();
        end
        while (mq.size() > 30) begin
            req = 0; rsp = 1;
            cycle();
        end
        idle_inputs();
        checks++; if (level !== 7'd30) begin failures++; $display("FAIL flush_pre_level got=%0d exp=30", level); end
        flush = 1; req = 1; rsp = 1; req_data = 32'h1234;
        cycle();
        idle_inputs();
        checks++; if (level !== 7'd0) begin failures++; $display("FAIL flush_level got=%0d exp=0", level); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL flush_empty got=%b exp=1", empty); end
        checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL flush_err got=%b%b exp=00", overflow, underflow); end
        rsp = 1;
        cycle();
        flush = 1; rsp = 0;
        cycle();
        idle_inputs();
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL flush_keeps_err got=%b exp=1", underflow); end
        err_clr = 1;
        cycle();
        err_clr = 0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            req = 1; req_data = WIDTH'(i);
            cycle();
        end
        checks++; if (level !== 7'd5) begin failures++; $display("FAIL rmid_pre_level got=%0d exp=5", level); end
        #3;
        reset = 1'b1;
        #1;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rmid_empty got=%b exp=1", empty); end
        checks++; if (level !== 7'd0) begin failures++; $display("FAIL rmid_level got=%0d exp=0", level); end
        @(posedge clk);
        #1;
        idle_inputs();
        reset = 1'b0;
        mq.delete(); m_ovf = 0; m_unf = 0;
        cycle();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rmid_post_empty got=%b exp=1", empty); end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        m_ovf = 0;
        m_unf = 0;
        test_reset();
        test_fill();
        test_full_push_pop();
        test_overflow_and_drain();
        test_empty_push_pop();
        test_random();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
Name: param_fifo

Overview:
- Parametrised successor to the team's fixed 64-entry buffer.
- Single-clock FIFO with power-of-two depth, show-ahead (first-word fall-through) read data and an occupancy count.
- Programmable almost-full and almost-empty flags, synchronous flush, and sticky overflow/underflow error flags.
- Sits between request producers (lane/memory front-ends) and consumers; drop-in for any point-to-point buffering in the vector datapath.

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- DEPTH, 64, number of entries; power of two, >=2. Elaboration-time assertion fails otherwise.
- AF_THRESH, DEPTH-4, almost_full asserts when level >= AF_THRESH (1..DEPTH).
- AE_THRESH, 4, almost_empty asserts when level <= AE_THRESH (0..DEPTH-1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of contents.
- req  in  1  push request.
- req_data  in  WIDTH  push data.
- full  out  1  level == DEPTH.
- almost_full  out  1  level >= AF_THRESH.
- rsp  in  1  pop request.
- rsp_data  out  WIDTH  head entry (valid when !empty).
- empty  out  1  level == 0.
- almost_empty  out  1  level <= AE_THRESH.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- err_clr  in  1  clears overflow/underflow.
- overflow  out  1  sticky: push refused.
- underflow  out  1  sticky: pop refused.

Behaviour:
- Pointers: rd_ptr and wr_ptr are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit. Storage index = pointer[$clog2(DEPTH)-1:0]. Pointers wrap naturally modulo 2*DEPTH.
- Flags are combinational from registered state:
  - empty: rd_ptr == wr_ptr.
  - full: index bits equal and wrap bits differ.
  - level: wr_ptr - rd_ptr, truncated to pointer width.
- Reset (async, high): pointers = 0 and error flags = 0. Outputs: empty=1, full=0, level=0, almost_empty=1, almost_full = (AF_THRESH==0 ? 1 : 0), which is 0 for legal values. rsp_data is don't-care while empty; the storage array is not reset.
- Pop accepted (pop_ok) = rsp && !empty. rd_ptr increments at the clock edge.
- Push accepted (push_ok) = req && (!full || pop_ok). When full, a simultaneous pop frees a slot and the push is taken in the same cycle; level stays DEPTH.
- Empty plus simultaneous push and pop: pop refused (no bypass), push taken. Next cycle level=1 and rsp_data = pushed word.
- Write latency: a word pushed at edge N appears on rsp_data after edge N if it becomes head (show-ahead, zero read latency).
- rsp_data = mem[rd_idx] is combinational from registered storage and pointer.
- Flush: synchronous, highest priority. At the edge, rd_ptr = wr_ptr = 0. Any req/rsp in that cycle is ignored and does not set error flags. Error flags are unaffected by flush.
- Errors:
  - overflow sets on req && !push_ok && !flush.
  - underflow sets on rsp && empty && !flush.
  - Both hold until err_clr; err_clr clears at the edge.
  - If err_clr coincides with a new error, set wins.
- Refused operations never modify pointers or storage.
- Reset mid-operation: immediate return to the reset state. Data in flight is lost; no partial write.

Decomposition:
- Package fifo_pkg:
  - function is_pow2(int) for the DEPTH check.
  - localparam helper ptr_w(DEPTH) = $clog2(DEPTH)+1.
  - typedef struct {overflow, underflow} fifo_err_t, for status aggregation by the CSR block.
- Sub-module fifo_mem: DEPTH x WIDTH array with one registered write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata). Storage only, no reset, so synthesis can map it to LUTRAM.
- param_fifo holds the pointers, flag, level and error logic.

Test Plan:
- Reset release, then 64 pushes of 0..63 with no pops -> full=1 after the 64th edge, level=64, almost_full=1 from level 60, overflow=0. Then pushes of 0..63 in order; rsp_data=0 throughout.
- From full, req=1 with rsp=1 for 10 cycles (data 100..109) -> full stays 1, level=64, no overflow. Popped data 0..9; later drain yields 10..63 then 100..109.
- Empty FIFO, req=1 with rsp=1 together, data 0xA5 -> underflow=1, level=1, rsp_data=0xA5 next cycle. err_clr pulse -> underflow=0.
- Push with full and no pop (data 0xFF) -> overflow=1, level stays 64, 0xFF never appears on rsp_data.
- Wrap-around: 200 random push/pop cycles at about 50% duty -> scoreboard order matches. level always equals pushes minus pops, empty/almost_empty (<=4) consistent, no spurious errors.
- Level 30, assert flush with req=1 and rsp=1 -> next cycle level=0, empty=1, no error flags set. Reset asserted mid-burst -> empty=1 immediately, before the next clock edge.
